// File: rtl/mult_pkg.sv
// Shared definitions for the Booth multiplier slice: default operand width
// and the controller state encoding.
package mult_pkg;

    localparam int MULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } mult_state_t;

endpackage

// File: rtl/booth_multiplier_if.sv
// Start/operand/result bundle between a requester and the Booth multiplier.
interface booth_multiplier_if import mult_pkg::*; #(
    parameter int WIDTH = MULT_WIDTH
) ();

    logic                 workMult;
    logic [WIDTH-1:0]     oper_A;
    logic [WIDTH-1:0]     oper_B;
    logic [2*WIDTH-1:0]   mul;
    logic                 endMult;
    logic                 busy;

    modport master (
        output workMult, oper_A, oper_B,
        input  mul, endMult, busy
    );

    modport slave (
        input  workMult, oper_A, oper_B,
        output mul, endMult, busy
    );

endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M followed by an
// arithmetic right shift of {acc, Q, Q(-1)}.
module booth_step import mult_pkg::*; #(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic             q_m1_in,
    input  logic [WIDTH-1:0] m_in,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] q_out,
    output logic             q_m1_out
);

    logic [WIDTH:0] acc_ext;
    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] sum;

    // One extra sign bit keeps acc - M exact even when M is the most negative value;
    // the shift then drops that bit back into a WIDTH-bit accumulator.
    always_comb begin
        acc_ext = {acc_in[WIDTH-1], acc_in};
        m_ext   = {m_in[WIDTH-1], m_in};
        case ({q_in[0], q_m1_in})
            2'b01:   sum = acc_ext + m_ext;
            2'b10:   sum = acc_ext - m_ext;
            default: sum = acc_ext;
        endcase
        acc_out  = sum[WIDTH:1];
        q_out    = {sum[0], q_in[WIDTH-1:1]};
        q_m1_out = q_in[0];
    end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed multiplier: IDLE/LOAD/ITER/DONE controller around a
// radix-2 Booth datapath, one iteration per clock.
module booth_multiplier import mult_pkg::*; #(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               Clk,
    input  logic               reset,
    booth_multiplier_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);

    mult_state_t          state;
    mult_state_t          next_state;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     q;
    logic                 q_m1;
    logic [CW-1:0]        count;
    logic [2*WIDTH-1:0]   mul_reg;
    logic [WIDTH-1:0]     acc_nxt;
    logic [WIDTH-1:0]     q_nxt;
    logic                 q_m1_nxt;
    logic                 busy_c;
    logic                 end_mult_c;
    logic                 last_iter;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc_in   (acc),
        .q_in     (q),
        .q_m1_in  (q_m1),
        .m_in     (a_reg),
        .acc_out  (acc_nxt),
        .q_out    (q_nxt),
        .q_m1_out (q_m1_nxt)
    );

    assign last_iter = (count == CW'(1));

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy_c     = 1'b1;
        end_mult_c = 1'b0;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (bus.workMult) begin
                    next_state = LOAD;
                end
            end
            LOAD: next_state = ITER;
            ITER: begin
                if (last_iter) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                end_mult_c = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Operands are frozen at the accepting edge; the product register is only
    // written by the final iteration so partial results never reach mul.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            count   <= '0;
            mul_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.workMult) begin
                        a_reg <= bus.oper_A;
                        b_reg <= bus.oper_B;
                    end
                end
                LOAD: begin
                    acc   <= '0;
                    q     <= b_reg;
                    q_m1  <= 1'b0;
                    count <= CW'(WIDTH);
                end
                ITER: begin
                    acc   <= acc_nxt;
                    q     <= q_nxt;
                    q_m1  <= q_m1_nxt;
                    count <= count - CW'(1);
                    if (last_iter) begin
                        mul_reg <= {acc_nxt, q_nxt};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mul     = mul_reg;
    assign bus.endMult = end_mult_c;
    assign bus.busy    = busy_c;

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed bench for booth_multiplier: stimulus pushes expected products and
// completion cycles into a scoreboard that an independent monitor drains.
module tb_booth_multiplier;

    localparam int WIDTH   = 32;
    localparam int LATENCY = WIDTH + 1;

    typedef struct {
        logic [2*WIDTH-1:0] prod;
        int                 due;
        string              name;
    } exp_t;

    logic Clk;
    logic reset;
    int   cyc;
    int   vectors;
    int   miscompares;
    exp_t sb[$];

    booth_multiplier_if #(.WIDTH(WIDTH)) bus ();

    booth_multiplier #(.WIDTH(WIDTH)) dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [2*WIDTH-1:0] act,
                               input logic [2*WIDTH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every endMult pulse must match the oldest outstanding operation
    always @(posedge Clk) begin
        #1;
        if (bus.endMult === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_endMult: got pulse at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput({e.name, "_mul"}, bus.mul, e.prod);
                checkOutput({e.name, "_cycle"}, 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic waitIdle();
        int n = 0;
        @(negedge Clk);
        while (bus.busy !== 1'b0 && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (bus.busy !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL wait_idle: busy=%b, expected 0 within 200 cycles", bus.busy);
        end
    endtask

    // Issues one start pulse; s returns the cycle index of the accepting edge
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [2*WIDTH-1:0] exp, input bit push,
                                 input string name, output int s);
        exp_t e;
        waitIdle();
        bus.oper_A   = a;
        bus.oper_B   = b;
        bus.workMult = 1'b1;
        @(posedge Clk);
        #1;
        s = cyc;
        if (push) begin
            e.prod = exp;
            e.due  = s + LATENCY;
            e.name = name;
            sb.push_back(e);
        end
        bus.workMult = 1'b0;
        bus.oper_A   = $urandom;
        bus.oper_B   = $urandom;
    endtask

    task automatic drainScoreboard(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge Clk);
            n++;
        end
        checkOutput(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #(50000 * 10);
        $display("[TB] FAIL watchdog: simulation did not finish within 50000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s;
        vectors      = 0;
        miscompares  = 0;
        cyc          = 0;
        reset        = 1'b0;
        bus.workMult = 1'b0;
        bus.oper_A   = '0;
        bus.oper_B   = '0;

        #12;
        checkOutput("reset_mul", bus.mul, 64'd0);
        checkOutput("reset_endMult", 64'(bus.endMult), 64'd0);
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        @(negedge Clk);
        reset = 1'b1;

        // Directed products with hand-computed results
        applyStimulus(32'd3, 32'd4, 64'h0000_0000_0000_000C, 1, "p_3x4", s);
        applyStimulus(-32'sd5, 32'd7, 64'hFFFF_FFFF_FFFF_FFDD, 1, "p_m5x7", s);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1, "p_m1xm1", s);
        applyStimulus(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1, "p_minxmin", s);
        applyStimulus(32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 1, "p_maxxmin", s);
        applyStimulus(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1, "p_maxxmax", s);
        applyStimulus(32'd0, 32'h1234_5678, 64'd0, 1, "p_0xk", s);
        drainScoreboard("directed_drain");

        // Start request while busy is ignored and busy never drops mid-operation
        applyStimulus(32'd2, 32'd3, 64'd6, 1, "busy_2x3", s);
        for (int k = 0; k <= LATENCY; k++) begin
            @(negedge Clk);
            checkOutput($sformatf("busy_high_%0d", k), 64'(bus.busy), 64'd1);
            if (k == 10) begin
                bus.oper_A   = 32'd9;
                bus.oper_B   = 32'd9;
                bus.workMult = 1'b1;
            end
            if (k == 20) bus.workMult = 1'b0;
        end
        @(negedge Clk);
        checkOutput("busy_idle_after", 64'(bus.busy), 64'd0);
        drainScoreboard("busy_drain");

        // Asynchronous reset mid-operation discards the product
        applyStimulus(32'd7, 32'd7, 64'd49, 0, "rst_7x7", s);
        while (cyc < s + 15) @(posedge Clk);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("midreset_mul", bus.mul, 64'd0);
        checkOutput("midreset_busy", 64'(bus.busy), 64'd0);
        checkOutput("midreset_endMult", 64'(bus.endMult), 64'd0);
        repeat (2) @(negedge Clk);
        reset = 1'b1;
        repeat (40) @(negedge Clk);
        applyStimulus(32'd7, 32'd7, 64'd49, 1, "post_rst_7x7", s);
        drainScoreboard("reset_drain");

        // workMult held high: DONE cycle ignored, next accept after one IDLE cycle
        waitIdle();
        bus.oper_A   = 32'd2;
        bus.oper_B   = 32'd5;
        bus.workMult = 1'b1;
        @(posedge Clk);
        #1;
        s = cyc;
        sb.push_back('{prod: 64'd10, due: s + LATENCY, name: "held_first"});
        sb.push_back('{prod: 64'd10, due: s + 2 * LATENCY + 2, name: "held_second"});
        repeat (40) @(negedge Clk);
        bus.workMult = 1'b0;
        drainScoreboard("held_drain");

        repeat (5) @(negedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
